// File: rtl/fwd_pkg.sv
// Shared encodings and helpers for the operand-forwarding / hazard unit.
// The forward-select encoding is: 0 = register file, k+1 = pipeline stage k,
// STAGES+1 = long-latency writeback bus.
package fwd_pkg;

  localparam int SEL_REGFILE = 0;

  // Width needed to encode regfile, every stage and the long-writeback bus.
  function automatic int sel_w_of(input int stages);
    return $clog2(stages + 2);
  endfunction

  function automatic int sel_stage(input int k);
    return k + 1;
  endfunction

  function automatic int sel_lwb(input int stages);
    return stages + 1;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand bypass lookup: picks the youngest matching downstream stage,
// falls back to the long-latency writeback bus, then to the register file,
// and flags a stall when the value is not yet obtainable.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_W  = 6,
  parameter int STAGES = 3,
  parameter int SEL_W  = 3
) (
  input  logic                      dec_valid,
  input  logic                      src_used,
  input  logic [REG_W-1:0]          src,
  input  logic                      src_busy,
  input  logic [STAGES-1:0]         stg_valid,
  input  logic [STAGES-1:0]         stg_wr,
  input  logic [STAGES-1:0]         stg_rdy,
  input  logic [STAGES*REG_W-1:0]   stg_dreg,
  input  logic                      lwb_valid,
  input  logic [REG_W-1:0]          lwb_dreg,
  output logic [SEL_W-1:0]          sel,
  output logic                      stall
);

  logic             eligible;
  logic             hit;
  logic             hit_rdy;
  logic [SEL_W-1:0] hit_sel;

  // Priority lookup: walk oldest to youngest so the youngest match overrides.
  // A source of r0 is never eligible, which also covers stages writing r0.
  always_comb begin
    eligible = dec_valid && src_used && (src != '0);
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_sel  = SEL_W'(SEL_REGFILE);
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (stg_valid[k] && stg_wr[k] && (stg_dreg[k*REG_W +: REG_W] == src)) begin
        hit     = 1'b1;
        hit_rdy = stg_rdy[k];
        hit_sel = SEL_W'(sel_stage(k));
      end
    end
  end

  // Select/stall decision; a matching but not-ready stage blocks any older source.
  always_comb begin
    sel   = SEL_W'(SEL_REGFILE);
    stall = 1'b0;
    if (eligible) begin
      if (hit) begin
        if (hit_rdy) sel = hit_sel;
        else         stall = 1'b1;
      end else if (lwb_valid && (lwb_dreg == src)) begin
        sel = SEL_W'(sel_lwb(STAGES));
      end else if (src_busy) begin
        stall = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and hazard unit beside decode. Owns the long-latency
// busy scoreboard, outstanding-op count and sticky error flag; per-operand
// lookup is done by fwd_src_match instances.
// Optional build macro FWD_STALL_CNT_EN adds a saturating stall_cycles counter.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int REG_W    = 6,
  parameter  int NSRC     = 2,
  parameter  int STAGES   = 3,
  parameter  int MAX_LONG = 4,
  localparam int SEL_W    = sel_w_of(STAGES),
  localparam int CNT_W    = $clog2(MAX_LONG + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dec_valid,
  input  logic                      dec_adv,
  input  logic [NSRC*REG_W-1:0]     dec_src,
  input  logic [NSRC-1:0]           dec_src_used,
  input  logic                      dec_wr,
  input  logic [REG_W-1:0]          dec_dreg,
  input  logic                      dec_long,
  input  logic [STAGES-1:0]         stg_valid,
  input  logic [STAGES-1:0]         stg_wr,
  input  logic [STAGES-1:0]         stg_rdy,
  input  logic [STAGES*REG_W-1:0]   stg_dreg,
  input  logic                      lwb_valid,
  input  logic [REG_W-1:0]          lwb_dreg,
  output logic [NSRC*SEL_W-1:0]     fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          busy_cnt,
  output logic                      err
`ifdef FWD_STALL_CNT_EN
  , output logic [31:0]             stall_cycles
`endif
);

  localparam int NREG = 1 << REG_W;

  logic [NREG-1:0]  busy;
  logic [NSRC-1:0]  src_stall;
  logic             waw_stall;
  logic             full_stall;
  logic             issue;
  logic             lwb_ok;
  logic             lwb_bad;
  logic [CNT_W-1:0] cnt_next;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_src_match #(
      .REG_W  (REG_W),
      .STAGES (STAGES),
      .SEL_W  (SEL_W)
    ) u_match (
      .dec_valid (dec_valid),
      .src_used  (dec_src_used[i]),
      .src       (dec_src[i*REG_W +: REG_W]),
      .src_busy  (busy[dec_src[i*REG_W +: REG_W]]),
      .stg_valid (stg_valid),
      .stg_wr    (stg_wr),
      .stg_rdy   (stg_rdy),
      .stg_dreg  (stg_dreg),
      .lwb_valid (lwb_valid),
      .lwb_dreg  (lwb_dreg),
      .sel       (fwd_sel[i*SEL_W +: SEL_W]),
      .stall     (src_stall[i])
    );
  end

  // Decode-level hazards: WAW against a busy destination, and a full long unit.
  // A same-cycle writeback to the destination (or any writeback when full)
  // frees the resource in time, so it cancels the corresponding stall.
  always_comb begin
    waw_stall  = dec_valid && dec_wr && (dec_dreg != '0) && busy[dec_dreg] &&
                 !(lwb_valid && (lwb_dreg == dec_dreg));
    full_stall = dec_valid && dec_long && (busy_cnt == CNT_W'(MAX_LONG)) && !lwb_valid;
    stall      = (|src_stall) || waw_stall || full_stall;
    issue      = dec_valid && dec_adv && !stall && dec_long;
    lwb_ok     = lwb_valid && busy[lwb_dreg];
    lwb_bad    = lwb_valid && !busy[lwb_dreg];
  end

  // Outstanding count, clamped so it can neither wrap above MAX_LONG nor below 0.
  always_comb begin
    cnt_next = busy_cnt;
    if (issue && !lwb_ok) begin
      if (busy_cnt != CNT_W'(MAX_LONG)) cnt_next = busy_cnt + 1'b1;
    end else if (!issue && lwb_ok) begin
      if (busy_cnt != '0) cnt_next = busy_cnt - 1'b1;
    end
  end

  // Scoreboard state; the set is written after the clear so set wins on the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (lwb_ok) busy[lwb_dreg] <= 1'b0;
      if (issue && dec_wr && (dec_dreg != '0)) busy[dec_dreg] <= 1'b1;
      busy_cnt <= cnt_next;
      if (lwb_bad) err <= 1'b1;
    end
  end

`ifdef FWD_STALL_CNT_EN
  // Saturating count of decode cycles lost to a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (dec_valid && stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios with constant
// expectations, then randomized traffic against a behavioural model.
module tb_fwd_scoreboard;

  localparam int REG_W    = 6;
  localparam int NSRC     = 2;
  localparam int STAGES   = 3;
  localparam int MAX_LONG = 4;
  localparam int SEL_W    = $clog2(STAGES + 2);
  localparam int CNT_W    = $clog2(MAX_LONG + 1);
  localparam int NREG     = 1 << REG_W;

  logic                    clk;
  logic                    reset;
  logic                    dec_valid;
  logic                    dec_adv;
  logic [NSRC*REG_W-1:0]   dec_src;
  logic [NSRC-1:0]         dec_src_used;
  logic                    dec_wr;
  logic [REG_W-1:0]        dec_dreg;
  logic                    dec_long;
  logic [STAGES-1:0]       stg_valid;
  logic [STAGES-1:0]       stg_wr;
  logic [STAGES-1:0]       stg_rdy;
  logic [STAGES*REG_W-1:0] stg_dreg;
  logic                    lwb_valid;
  logic [REG_W-1:0]        lwb_dreg;
  logic [NSRC*SEL_W-1:0]   fwd_sel;
  logic                    stall;
  logic [CNT_W-1:0]        busy_cnt;
  logic                    err;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]             stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  bit mbusy [NREG];
  int mcnt;
  bit merr;
  longint mstalls;
  int exp_sel [NSRC];
  bit exp_ostall [NSRC];
  bit exp_stall;

  fwd_scoreboard #(
    .REG_W(REG_W), .NSRC(NSRC), .STAGES(STAGES), .MAX_LONG(MAX_LONG)
  ) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_adv(dec_adv), .dec_src(dec_src),
    .dec_src_used(dec_src_used), .dec_wr(dec_wr), .dec_dreg(dec_dreg),
    .dec_long(dec_long), .stg_valid(stg_valid), .stg_wr(stg_wr),
    .stg_rdy(stg_rdy), .stg_dreg(stg_dreg), .lwb_valid(lwb_valid),
    .lwb_dreg(lwb_dreg), .fwd_sel(fwd_sel), .stall(stall),
    .busy_cnt(busy_cnt), .err(err)
`ifdef FWD_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int src_of(input int i);
    return int'(dec_src[i*REG_W +: REG_W]);
  endfunction

  // Expected select/stall straight from the forwarding rules.
  function automatic void model_eval();
    int s, found;
    exp_stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      s = src_of(i);
      exp_sel[i] = 0;
      exp_ostall[i] = 1'b0;
      if (dec_valid && dec_src_used[i] && s != 0) begin
        found = -1;
        for (int k = 0; k < STAGES; k++)
          if (found < 0 && stg_valid[k] && stg_wr[k] && int'(stg_dreg[k*REG_W +: REG_W]) == s)
            found = k;
        if (found >= 0) begin
          if (stg_rdy[found]) exp_sel[i] = found + 1;
          else exp_ostall[i] = 1'b1;
        end else if (lwb_valid && int'(lwb_dreg) == s) exp_sel[i] = STAGES + 1;
        else if (mbusy[s]) exp_ostall[i] = 1'b1;
      end
      if (exp_ostall[i]) exp_stall = 1'b1;
    end
    if (dec_valid && dec_wr && dec_dreg != 0 && mbusy[dec_dreg] &&
        !(lwb_valid && lwb_dreg == dec_dreg)) exp_stall = 1'b1;
    if (dec_valid && dec_long && mcnt == MAX_LONG && !lwb_valid) exp_stall = 1'b1;
  endfunction

  function automatic void model_commit();
    bit iss, vl;
    int n;
    model_eval();
    iss = dec_valid && dec_adv && !exp_stall && dec_long;
    vl  = lwb_valid && mbusy[lwb_dreg];
    if (dec_valid && exp_stall && mstalls < 64'hFFFF_FFFF) mstalls++;
    if (lwb_valid && !mbusy[lwb_dreg]) merr = 1'b1;
    if (vl) mbusy[lwb_dreg] = 1'b0;
    if (iss && dec_wr && dec_dreg != 0) mbusy[dec_dreg] = 1'b1;
    n = mcnt + (iss ? 1 : 0) - (vl ? 1 : 0);
    if (n > MAX_LONG) n = MAX_LONG;
    if (n < 0) n = 0;
    mcnt = n;
  endfunction

  function automatic void model_reset();
    foreach (mbusy[r]) mbusy[r] = 1'b0;
    mcnt = 0;
    merr = 1'b0;
    mstalls = 0;
  endfunction

  task automatic clear_inputs();
    dec_valid = 0; dec_adv = 0; dec_src = '0; dec_src_used = '0;
    dec_wr = 0; dec_dreg = '0; dec_long = 0;
    stg_valid = '0; stg_wr = '0; stg_rdy = '0; stg_dreg = '0;
    lwb_valid = 0; lwb_dreg = '0;
  endtask

  task automatic cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic issue_long(input int r);
    clear_inputs();
    dec_valid = 1; dec_adv = 1; dec_long = 1; dec_wr = 1; dec_dreg = REG_W'(r);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL issue_stall r%0d got=%0b exp=0", r, stall);
    end
    cycle();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (busy_cnt !== '0 || err !== 1'b0 || stall !== 1'b0 || fwd_sel !== '0) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d err=%0b stall=%0b sel=%0h exp 0/0/0/0",
               busy_cnt, err, stall, fwd_sel);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_stage_fwd();
    clear_inputs();
    dec_valid = 1; dec_src_used = 2'b01; dec_src[0 +: REG_W] = 6'd5;
    stg_valid[0] = 1; stg_wr[0] = 1; stg_rdy[0] = 1; stg_dreg[0 +: REG_W] = 6'd5;
    #1;
    checks++;
    if (fwd_sel[0 +: SEL_W] !== 3'd1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL stage0_fwd got sel=%0d stall=%0b exp sel=1 stall=0", fwd_sel[0 +: SEL_W], stall);
    end
    stg_rdy[0] = 0;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL stage0_notrdy got stall=%0b exp=1", stall);
    end
    cycle();
  endtask

  task automatic test_priority();
    clear_inputs();
    dec_valid = 1; dec_src_used = 2'b10; dec_src[REG_W +: REG_W] = 6'd7;
    stg_valid = 3'b101; stg_wr = 3'b101; stg_rdy = 3'b101;
    stg_dreg[0 +: REG_W] = 6'd7; stg_dreg[2*REG_W +: REG_W] = 6'd7;
    #1;
    checks++;
    if (fwd_sel[SEL_W +: SEL_W] !== 3'd1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL youngest_wins got sel=%0d stall=%0b exp sel=1 stall=0", fwd_sel[SEL_W +: SEL_W], stall);
    end
    dec_src_used = 2'b01; dec_src = '0;
    stg_valid = 3'b111; stg_wr = 3'b111; stg_rdy = 3'b000; stg_dreg = '0;
    #1;
    checks++;
    if (fwd_sel !== '0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL r0_src got sel=%0h stall=%0b exp sel=0 stall=0", fwd_sel, stall);
    end
    cycle();
  endtask

  task automatic test_long_op();
    do_reset();
    issue_long(9);
    clear_inputs();
    dec_valid = 1; dec_src_used = 2'b01; dec_src[0 +: REG_W] = 6'd9;
    #1;
    checks++;
    if (stall !== 1'b1 || busy_cnt !== 3'd1) begin
      errors++;
      $display("FAIL long_raw got stall=%0b cnt=%0d exp stall=1 cnt=1", stall, busy_cnt);
    end
    lwb_valid = 1; lwb_dreg = 6'd9;
    #1;
    checks++;
    if (fwd_sel[0 +: SEL_W] !== 3'(STAGES + 1) || stall !== 1'b0) begin
      errors++;
      $display("FAIL lwb_fwd got sel=%0d stall=%0b exp sel=%0d stall=0", fwd_sel[0 +: SEL_W], stall, STAGES + 1);
    end
    cycle();
    clear_inputs();
    #1;
    checks++;
    if (busy_cnt !== 3'd0) begin
      errors++;
      $display("FAIL lwb_clear_cnt got=%0d exp=0", busy_cnt);
    end
  endtask

  task automatic test_max_long();
    do_reset();
    for (int r = 1; r <= MAX_LONG; r++) issue_long(r);
    clear_inputs();
    dec_valid = 1; dec_adv = 1; dec_long = 1; dec_wr = 1; dec_dreg = 6'd20;
    #1;
    checks++;
    if (stall !== 1'b1 || busy_cnt !== 3'(MAX_LONG)) begin
      errors++;
      $display("FAIL full_stall got stall=%0b cnt=%0d exp stall=1 cnt=%0d", stall, busy_cnt, MAX_LONG);
    end
    lwb_valid = 1; lwb_dreg = 6'd1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL full_with_lwb got stall=%0b exp=0", stall);
    end
    cycle();
    clear_inputs();
    #1;
    checks++;
    if (busy_cnt !== 3'(MAX_LONG)) begin
      errors++;
      $display("FAIL full_cnt_hold got=%0d exp=%0d", busy_cnt, MAX_LONG);
    end
  endtask

  task automatic test_waw();
    do_reset();
    issue_long(3);
    clear_inputs();
    dec_valid = 1; dec_adv = 1; dec_wr = 1; dec_dreg = 6'd3; dec_long = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL waw_stall got=%0b exp=1", stall);
    end
    lwb_valid = 1; lwb_dreg = 6'd3;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL waw_lwb got=%0b exp=0", stall);
    end
    cycle();
    clear_inputs();
    dec_valid = 1; dec_src_used = 2'b10; dec_src[REG_W +: REG_W] = 6'd3;
    #1;
    checks++;
    if (stall !== 1'b1 || busy_cnt !== 3'd1) begin
      errors++;
      $display("FAIL waw_set_wins got stall=%0b cnt=%0d exp stall=1 cnt=1", stall, busy_cnt);
    end
    cycle();
  endtask

  task automatic test_err_reset();
    do_reset();
    for (int r = 1; r <= 3; r++) issue_long(r);
    clear_inputs();
    lwb_valid = 1; lwb_dreg = 6'd12;
    cycle();
    clear_inputs();
    dec_valid = 1; dec_src_used = 2'b01; dec_src[0 +: REG_W] = 6'd1;
    #1;
    checks++;
    if (err !== 1'b1 || busy_cnt !== 3'd3 || stall !== 1'b1) begin
      errors++;
      $display("FAIL err_set got err=%0b cnt=%0d stall=%0b exp 1/3/1", err, busy_cnt, stall);
    end
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (err !== 1'b0 || busy_cnt !== 3'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got err=%0b cnt=%0d stall=%0b exp 0/0/0", err, busy_cnt, stall);
    end
    #1;
    reset = 1'b0;
    clear_inputs();
    cycle();
  endtask

  task automatic rand_inputs();
    int q[$];
    dec_valid = ($urandom_range(0, 3) != 0);
    dec_adv   = ($urandom_range(0, 3) != 0);
    dec_src_used = NSRC'($urandom);
    for (int i = 0; i < NSRC; i++) dec_src[i*REG_W +: REG_W] = REG_W'($urandom_range(0, 7));
    dec_wr   = ($urandom_range(0, 4) != 0);
    dec_dreg = REG_W'($urandom_range(0, 7));
    dec_long = ($urandom_range(0, 2) == 0);
    stg_valid = STAGES'($urandom);
    stg_wr    = STAGES'($urandom);
    stg_rdy   = STAGES'($urandom);
    for (int k = 0; k < STAGES; k++) stg_dreg[k*REG_W +: REG_W] = REG_W'($urandom_range(0, 7));
    lwb_valid = ($urandom_range(0, 2) == 0);
    for (int r = 0; r < NREG; r++) if (mbusy[r]) q.push_back(r);
    if (q.size() > 0 && $urandom_range(0, 9) != 0)
      lwb_dreg = REG_W'(q[$urandom_range(0, q.size() - 1)]);
    else
      lwb_dreg = REG_W'($urandom_range(0, 15));
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rand_inputs();
      #1;
      model_eval();
      checks++;
      if (stall !== exp_stall) begin
        errors++;
        $display("FAIL rand_stall cyc=%0d got=%0b exp=%0b", c, stall, exp_stall);
      end
      for (int i = 0; i < NSRC; i++) begin
        if (!exp_ostall[i]) begin
          checks++;
          if (fwd_sel[i*SEL_W +: SEL_W] !== SEL_W'(exp_sel[i])) begin
            errors++;
            $display("FAIL rand_sel%0d cyc=%0d got=%0d exp=%0d", i, c, fwd_sel[i*SEL_W +: SEL_W], exp_sel[i]);
          end
        end
      end
      checks++;
      if (busy_cnt !== CNT_W'(mcnt) || err !== merr) begin
        errors++;
        $display("FAIL rand_state cyc=%0d got cnt=%0d err=%0b exp cnt=%0d err=%0b", c, busy_cnt, err, mcnt, merr);
      end
`ifdef FWD_STALL_CNT_EN
      checks++;
      if (stall_cycles !== 32'(mstalls)) begin
        errors++;
        $display("FAIL rand_stall_cycles cyc=%0d got=%0d exp=%0d", c, stall_cycles, mstalls);
      end
`endif
      cycle();
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    model_reset();
    #2;
    test_reset();
    test_stage_fwd();
    test_priority();
    test_long_op();
    test_max_long();
    test_waw();
    test_err_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
